// File: rtl/shift_sequencer.sv
// Iterative shifter: one logarithmic stage (shift by 2^k) per cycle.
// SLL/SRL/SRA are supported, with valid/ready handshakes on request and result.
module shift_sequencer #(
    parameter int XLEN       = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_mode,
    input  logic            i_direction,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);
    // state | meaning
    // IDLE  | waiting for a request, o_ready high
    // SHIFT | applying stage k (shift by 2^k when shamt[k] is set)
    // DONE  | result held on o_result until consumer takes it
    localparam int SW = $clog2(XLEN);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [SW-1:0] K_LAST = SW'(SW - 1);
    localparam logic [SW-1:0] ONE    = SW'(1);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] data_q,  data_d;
    logic [SW-1:0]   shamt_q, shamt_d;
    logic            mode_q,  mode_d;
    logic            dir_q,   dir_d;
    logic [SW-1:0]   k_q,     k_d;

    logic [SW-1:0]   stage_amt;
    logic [SW-1:0]   shamt_hi;
    logic [XLEN-1:0] shifted;
    logic            last_stage;
    logic            unused_b;

    assign unused_b = ^i_b[XLEN-1:SW];

    always_comb begin
        stage_amt = ONE << k_q;
        shamt_hi  = shamt_q >> k_q;
        shifted   = data_q;
        if (dir_q) begin
            if (mode_q) begin
                shifted = XLEN'($signed(data_q) >>> stage_amt);
            end else begin
                shifted = data_q >> stage_amt;
            end
        end else begin
            shifted = data_q << stage_amt;
        end
        // Early exit once no shift-amount bit above the current stage remains.
        last_stage = (k_q == K_LAST) || (EARLY_EXIT && (shamt_hi[SW-1:1] == '0));
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        k_d     = k_q;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        data_d  = i_a;
                        shamt_d = i_b[SW-1:0];
                        mode_d  = i_mode;
                        dir_d   = i_direction;
                        k_d     = '0;
                        if (EARLY_EXIT && (i_b[SW-1:0] == '0)) begin
                            state_d = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (shamt_q[k_q]) begin
                        data_d = shifted;
                    end
                    if (last_stage) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + ONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            k_q     <= k_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_busy   = (state_q != IDLE);
    assign o_result = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: one instance with early exit, one without.
module tb_shift_sequencer;
    logic        clk;
    logic        rst_n;
    logic        mode, dir;
    logic [31:0] a, b;

    logic        flush1, valid1, ready_in1;
    logic        ready1, ovalid1, busy1;
    logic [31:0] result1;

    logic        flush2, valid2, ready_in2;
    logic        ready2, ovalid2, busy2;
    logic [31:0] result2;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.XLEN(32), .EARLY_EXIT(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush1), .i_valid(valid1),
        .o_ready(ready1), .i_mode(mode), .i_direction(dir), .i_a(a), .i_b(b),
        .o_valid(ovalid1), .i_ready(ready_in1), .o_result(result1), .o_busy(busy1)
    );

    shift_sequencer #(.XLEN(32), .EARLY_EXIT(1'b0)) dut_ne (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush2), .i_valid(valid2),
        .o_ready(ready2), .i_mode(mode), .i_direction(dir), .i_a(a), .i_b(b),
        .o_valid(ovalid2), .i_ready(ready_in2), .o_result(result2), .o_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request on the selected instance (0 = early exit, 1 = full run)
    // and waits for o_valid; lat is -1 on timeout, busy_ok clears if busy drops early.
    task automatic run_op(input bit sel, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tmode, input logic tdir,
                          output logic [31:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        a = ta; b = tb; mode = tmode; dir = tdir;
        if (sel) valid2 = 1'b1; else valid1 = 1'b1;
        @(posedge clk);
        #1;
        valid1 = 1'b0; valid2 = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'hFFFF_FFFF; mode = ~tmode; dir = ~tdir;
        lat = -1;
        busy_ok = 1'b1;
        res = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!(sel ? busy2 : busy1)) busy_ok = 1'b0;
            if (sel ? ovalid2 : ovalid1) begin
                lat = c;
                res = sel ? result2 : result1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({ready1, ovalid1, busy1} !== 3'b100 || result1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_ee: ready/valid/busy=%b result=%h, want 100 00000000",
                     {ready1, ovalid1, busy1}, result1);
        end
        checks++;
        if ({ready2, ovalid2, busy2} !== 3'b100 || result2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_ne: ready/valid/busy=%b result=%h, want 100 00000000",
                     {ready2, ovalid2, busy2}, result2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sll_max();
        logic [31:0] r; int lat; bit bok;
        run_op(1'b0, 32'h1, 32'd31, 1'b0, 1'b0, r, lat, bok);
        checks++;
        if (r !== 32'h8000_0000 || lat != 6) begin
            errors++;
            $display("FAIL sll31: result=%h lat=%0d, want 80000000 lat=6", r, lat);
        end
        checks++;
        if (!bok) begin
            errors++;
            $display("FAIL sll31_busy: busy low in cycles 1..6, want high");
        end
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || ready1 !== 1'b1) begin
            errors++;
            $display("FAIL sll31_idle: busy=%b ready=%b, want 0 1", busy1, ready1);
        end
    endtask

    task automatic test_right_shifts();
        logic [31:0] r; int lat; bit bok;
        run_op(1'b0, 32'h8000_0000, 32'd4, 1'b1, 1'b1, r, lat, bok);
        checks++;
        if (r !== 32'hF800_0000 || lat != 4) begin
            errors++;
            $display("FAIL sra4: result=%h lat=%0d, want f8000000 lat=4", r, lat);
        end
        run_op(1'b0, 32'h8000_0000, 32'd4, 1'b0, 1'b1, r, lat, bok);
        checks++;
        if (r !== 32'h0800_0000 || lat != 4) begin
            errors++;
            $display("FAIL srl4: result=%h lat=%0d, want 08000000 lat=4", r, lat);
        end
        run_op(1'b0, 32'hC000_0001, 32'd1, 1'b1, 1'b0, r, lat, bok);
        checks++;
        if (r !== 32'h8000_0002 || lat != 2) begin
            errors++;
            $display("FAIL sla1: result=%h lat=%0d, want 80000002 lat=2", r, lat);
        end
        run_op(1'b0, 32'h8000_0000, 32'd31, 1'b1, 1'b1, r, lat, bok);
        checks++;
        if (r !== 32'hFFFF_FFFF || lat != 6) begin
            errors++;
            $display("FAIL sra31: result=%h lat=%0d, want ffffffff lat=6", r, lat);
        end
        run_op(1'b0, 32'h1234_5678, 32'd12, 1'b0, 1'b0, r, lat, bok);
        checks++;
        if (r !== 32'h4567_8000 || lat != 5) begin
            errors++;
            $display("FAIL sll12: result=%h lat=%0d, want 45678000 lat=5", r, lat);
        end
    endtask

    task automatic test_mask_early_exit();
        logic [31:0] r; int lat; bit bok;
        run_op(1'b0, 32'h1, 32'h21, 1'b0, 1'b0, r, lat, bok);
        checks++;
        if (r !== 32'h2 || lat != 2) begin
            errors++;
            $display("FAIL mask21_ee: result=%h lat=%0d, want 00000002 lat=2", r, lat);
        end
        run_op(1'b0, 32'h1234_5678, 32'h20, 1'b0, 1'b0, r, lat, bok);
        checks++;
        if (r !== 32'h1234_5678 || lat != 1) begin
            errors++;
            $display("FAIL mask20_ee: result=%h lat=%0d, want 12345678 lat=1", r, lat);
        end
        run_op(1'b1, 32'h1, 32'h21, 1'b0, 1'b0, r, lat, bok);
        checks++;
        if (r !== 32'h2 || lat != 6) begin
            errors++;
            $display("FAIL mask21_ne: result=%h lat=%0d, want 00000002 lat=6", r, lat);
        end
        run_op(1'b1, 32'h1234_5678, 32'h20, 1'b0, 1'b0, r, lat, bok);
        checks++;
        if (r !== 32'h1234_5678 || lat != 6) begin
            errors++;
            $display("FAIL mask20_ne: result=%h lat=%0d, want 12345678 lat=6", r, lat);
        end
        run_op(1'b1, 32'h8000_0000, 32'd4, 1'b1, 1'b1, r, lat, bok);
        checks++;
        if (r !== 32'hF800_0000 || lat != 6) begin
            errors++;
            $display("FAIL sra4_ne: result=%h lat=%0d, want f8000000 lat=6", r, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; int lat; bit bok;
        ready_in1 = 1'b0;
        run_op(1'b0, 32'h0000_00F0, 32'd2, 1'b0, 1'b1, r, lat, bok);
        checks++;
        if (r !== 32'h0000_003C || lat != 3) begin
            errors++;
            $display("FAIL bp_result: result=%h lat=%0d, want 0000003c lat=3", r, lat);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ovalid1 !== 1'b1 || result1 !== 32'h0000_003C || ready1 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b result=%h ready=%b, want 1 0000003c 0",
                         c, ovalid1, result1, ready1);
            end
        end
        ready_in1 = 1'b1;
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b1 || ovalid1 !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b, want 1 0", ready1, ovalid1);
        end
        a = 32'h1; b = 32'd3; mode = 1'b0; dir = 1'b0; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept: busy=%b, want 1", busy1);
        end
        for (int c = 0; c < 20 && !ovalid1; c++) @(negedge clk);
        checks++;
        if (ovalid1 !== 1'b1 || result1 !== 32'h8) begin
            errors++;
            $display("FAIL bp_next_result: valid=%b result=%h, want 1 00000008", ovalid1, result1);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat; bit bok;
        bit seen;
        @(negedge clk);
        a = 32'h1; b = 32'd31; mode = 1'b0; dir = 1'b0; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush1 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0;
        checks++;
        if (ready1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_shift: ready=%b busy=%b, want 1 0", ready1, busy1);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ovalid1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_novalid: o_valid=1 after flush, want 0");
        end

        a = 32'h1; b = 32'd0; valid1 = 1'b1; flush1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0; flush1 = 1'b0;
        checks++;
        if (ready1 !== 1'b1 || busy1 !== 1'b0 || ovalid1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_accept: ready=%b busy=%b valid=%b, want 1 0 0",
                     ready1, busy1, ovalid1);
        end

        ready_in1 = 1'b0;
        run_op(1'b0, 32'h5, 32'd1, 1'b0, 1'b0, r, lat, bok);
        checks++;
        if (r !== 32'hA || lat != 2) begin
            errors++;
            $display("FAIL flush_done_pre: result=%h lat=%0d, want 0000000a lat=2", r, lat);
        end
        ready_in1 = 1'b1; flush1 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0;
        checks++;
        if (ready1 !== 1'b1 || ovalid1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: ready=%b valid=%b busy=%b, want 1 0 0",
                     ready1, ovalid1, busy1);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] r; int lat; bit bok;
        @(negedge clk);
        a = 32'h1; b = 32'd31; mode = 1'b0; dir = 1'b0; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready1, ovalid1, busy1} !== 3'b100 || result1 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: ready/valid/busy=%b result=%h, want 100 00000000",
                     {ready1, ovalid1, busy1}, result1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 32'hFFFF_FFFF, 32'd8, 1'b0, 1'b1, r, lat, bok);
        checks++;
        if (r !== 32'h00FF_FFFF || lat != 5) begin
            errors++;
            $display("FAIL srl8_after_reset: result=%h lat=%0d, want 00ffffff lat=5", r, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush1 = 1'b0; valid1 = 1'b0; ready_in1 = 1'b1;
        flush2 = 1'b0; valid2 = 1'b0; ready_in2 = 1'b1;
        a = '0; b = '0; mode = 1'b0; dir = 1'b0;
        test_reset();
        test_sll_max();
        test_right_shifts();
        test_mask_early_exit();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
